// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer: NS/EW signal heads plus pedestrian walk,
// stepped by rising edges of the divided-clock tick and driven by latched demand.
module traffic_phase_controller #(
    parameter int unsigned GREEN_NS = 10,
    parameter int unsigned GREEN_EW = 8,
    parameter int unsigned YELLOW   = 3,
    parameter int unsigned ALL_RED  = 1,
    parameter int unsigned WALK     = 5
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [4:0] time_left,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G     = 3'd0,
        NS_Y     = 3'd1,
        RED1     = 3'd2,
        EW_G     = 3'd3,
        EW_Y     = 3'd4,
        RED2     = 3'd5,
        PED_WALK = 3'd6
    } state_t;

    localparam logic [4:0] D_GREEN_NS = 5'(GREEN_NS);
    localparam logic [4:0] D_GREEN_EW = 5'(GREEN_EW);
    localparam logic [4:0] D_YELLOW   = 5'(YELLOW);
    localparam logic [4:0] D_ALL_RED  = 5'(ALL_RED);
    localparam logic [4:0] D_WALK     = 5'(WALK);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    state_t     state, state_next;
    logic [4:0] timer, timer_next;
    logic       tick_prev;
    logic       tick;
    logic       expire;
    logic       ew_pending, ped_pending;
    logic       enter_ew, enter_walk;

    assign tick   = tick_in & ~tick_prev;
    assign expire = tick && (timer <= 5'd1);

    // State register, tick edge detector and demand latches.
    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            state       <= RED2;
            timer       <= D_ALL_RED;
            tick_prev   <= 1'b1;
            ew_pending  <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            tick_prev   <= tick_in;
            // Clear on service entry wins over a simultaneous new request.
            ew_pending  <= enter_ew   ? 1'b0 : (ew_pending  | ew_car);
            ped_pending <= enter_walk ? 1'b0 : (ped_pending | ped_req);
        end
    end

    // Next-state and timer: phase changes only on the expiring tick,
    // with the next dwell loaded in the same cycle.
    always_comb begin
        state_next = state;
        timer_next = timer;
        if (tick && !expire) begin
            timer_next = timer - 5'd1;
        end
        case (state)
            NS_G: begin
                if (expire) begin
                    if (ew_pending || ped_pending) begin
                        state_next = NS_Y;
                        timer_next = D_YELLOW;
                    end else begin
                        timer_next = D_GREEN_NS;
                    end
                end
            end
            NS_Y: begin
                if (expire) begin
                    state_next = RED1;
                    timer_next = D_ALL_RED;
                end
            end
            RED1: begin
                if (expire) begin
                    if (ew_pending) begin
                        state_next = EW_G;
                        timer_next = D_GREEN_EW;
                    end else begin
                        state_next = RED2;
                        timer_next = D_ALL_RED;
                    end
                end
            end
            EW_G: begin
                if (expire) begin
                    state_next = EW_Y;
                    timer_next = D_YELLOW;
                end
            end
            EW_Y: begin
                if (expire) begin
                    state_next = RED2;
                    timer_next = D_ALL_RED;
                end
            end
            RED2: begin
                if (expire) begin
                    if (ped_pending) begin
                        state_next = PED_WALK;
                        timer_next = D_WALK;
                    end else begin
                        state_next = NS_G;
                        timer_next = D_GREEN_NS;
                    end
                end
            end
            PED_WALK: begin
                if (expire) begin
                    state_next = NS_G;
                    timer_next = D_GREEN_NS;
                end
            end
            default: begin
                state_next = RED2;
                timer_next = D_ALL_RED;
            end
        endcase
    end

    assign enter_ew   = (state_next == EW_G)     && (state != EW_G);
    assign enter_walk = (state_next == PED_WALK) && (state != PED_WALK);

    // Moore output decode; anything unrecognised shows all red.
    always_comb begin
        ns_light = RED;
        ew_light = RED;
        walk     = 1'b0;
        case (state)
            NS_G:     ns_light = GRN;
            NS_Y:     ns_light = YEL;
            EW_G:     ew_light = GRN;
            EW_Y:     ew_light = YEL;
            PED_WALK: walk     = 1'b1;
            default: begin
                ns_light = RED;
                ew_light = RED;
                walk     = 1'b0;
            end
        endcase
    end

    assign time_left = timer;
    assign phase     = state;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller: stimulus pushes expected outputs
// into a queue, a monitor pops and compares; a per-cycle check guards safety.
module tb_traffic_phase_controller;

    logic       CLK100MHZ;
    logic       reset;
    logic       tick_in;
    logic       ew_car;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic [4:0] time_left;
    logic [2:0] phase;

    traffic_phase_controller #(
        .GREEN_NS(10),
        .GREEN_EW(8),
        .YELLOW  (3),
        .ALL_RED (1),
        .WALK    (5)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .tick_in  (tick_in),
        .ew_car   (ew_car),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .time_left(time_left),
        .phase    (phase)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic [4:0] tl;
        logic [2:0] ph;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-written light table per phase: {ns, ew, walk}.
    function automatic logic [6:0] lights_for(input logic [2:0] ph);
        case (ph)
            3'd0:    return 7'b001_100_0;
            3'd1:    return 7'b010_100_0;
            3'd2:    return 7'b100_100_0;
            3'd3:    return 7'b100_001_0;
            3'd4:    return 7'b100_010_0;
            3'd5:    return 7'b100_100_0;
            3'd6:    return 7'b100_100_1;
            default: return 7'b100_100_0;
        endcase
    endfunction

    task automatic push(input logic [2:0] ph, input logic [4:0] tl, input string nm);
        exp_t       e;
        logic [6:0] l;
        l    = lights_for(ph);
        e.ns = l[6:4];
        e.ew = l[3:1];
        e.wk = l[0];
        e.tl = tl;
        e.ph = ph;
        e.nm = nm;
        q.push_back(e);
    endtask

    task automatic tick_exp(input logic [2:0] ph, input logic [4:0] tl, input string nm);
        @(negedge CLK100MHZ) tick_in = 1'b1;
        @(negedge CLK100MHZ) tick_in = 1'b0;
        push(ph, tl, nm);
    endtask

    // Full phase from its entry tick: time_left shows dwell down to 1.
    task automatic run_phase(input logic [2:0] ph, input int dwell, input string nm);
        for (int k = dwell; k >= 1; k--) begin
            tick_exp(ph, 5'(k), nm);
        end
    endtask

    task automatic pulse(input logic ew, input logic pd);
        @(negedge CLK100MHZ);
        ew_car  = ew;
        ped_req = pd;
        @(negedge CLK100MHZ);
        ew_car  = 1'b0;
        ped_req = 1'b0;
    endtask

    // Monitor: compare every queued expectation against live outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK100MHZ);
            #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({ns_light, ew_light, walk, time_left, phase} !==
                    {e.ns, e.ew, e.wk, e.tl, e.ph}) begin
                    errors++;
                    $display("FAIL %s: got ns=%b ew=%b walk=%b tl=%0d ph=%0d, want ns=%b ew=%b walk=%b tl=%0d ph=%0d",
                             e.nm, ns_light, ew_light, walk, time_left, phase,
                             e.ns, e.ew, e.wk, e.tl, e.ph);
                end
            end
        end
    end

    // Safety invariant, every cycle out of reset.
    always @(negedge CLK100MHZ) begin
        if (reset === 1'b1) begin
            checks++;
            if (!((ns_light == 3'b100) || (ew_light == 3'b100)) ||
                (walk && !((ns_light == 3'b100) && (ew_light == 3'b100))) ||
                !$onehot(ns_light) || !$onehot(ew_light)) begin
                errors++;
                $display("FAIL safety: got ns=%b ew=%b walk=%b, want one head red, both red when walking",
                         ns_light, ew_light, walk);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        tick_in = 1'b1;
        ew_car  = 1'b0;
        ped_req = 1'b0;
        repeat (5) @(negedge CLK100MHZ);
        reset = 1'b1;
        @(negedge CLK100MHZ);
        push(3'd5, 5'd1, "reset_state");
        @(negedge CLK100MHZ) tick_in = 1'b0;
        @(negedge CLK100MHZ);
        tick_exp(3'd0, 5'd10, "first_tick");

        // Rest on NS green with no demand.
        for (int k = 1; k <= 25; k++) begin
            tick_exp(3'd0, ((k % 10) == 0) ? 5'd10 : 5'(10 - (k % 10)), "ns_rest");
        end

        // EW car only.
        pulse(1'b1, 1'b0);
        for (int k = 4; k >= 1; k--) tick_exp(3'd0, 5'(k), "ns_before_ew");
        run_phase(3'd1, 3, "ew_ns_y");
        run_phase(3'd2, 1, "ew_red1");
        run_phase(3'd3, 8, "ew_green");
        run_phase(3'd4, 3, "ew_yellow");
        run_phase(3'd5, 1, "ew_red2");
        run_phase(3'd0, 10, "ew_back_ns");

        // Pedestrian only, button held through WALK entry.
        @(negedge CLK100MHZ) ped_req = 1'b1;
        run_phase(3'd1, 3, "ped_ns_y");
        run_phase(3'd2, 1, "ped_red1");
        run_phase(3'd5, 1, "ped_red2_skip_ew");
        tick_exp(3'd6, 5'd5, "walk_entry");
        ped_req = 1'b0;
        for (int k = 4; k >= 1; k--) tick_exp(3'd6, 5'(k), "walk");
        run_phase(3'd0, 10, "ped_back_ns");
        tick_exp(3'd0, 5'd10, "no_second_walk");

        // Both demands.
        pulse(1'b1, 1'b1);
        for (int k = 9; k >= 1; k--) tick_exp(3'd0, 5'(k), "both_ns");
        run_phase(3'd1, 3, "both_ns_y");
        run_phase(3'd2, 1, "both_red1");
        run_phase(3'd3, 8, "both_ew_g");
        run_phase(3'd4, 3, "both_ew_y");
        run_phase(3'd5, 1, "both_red2");
        run_phase(3'd6, 5, "both_walk");
        run_phase(3'd0, 10, "both_back_ns");

        // Reset in the middle of EW green with both demands latched.
        pulse(1'b1, 1'b0);
        run_phase(3'd1, 3, "mid_ns_y");
        run_phase(3'd2, 1, "mid_red1");
        for (int k = 8; k >= 4; k--) tick_exp(3'd3, 5'(k), "mid_ew_g");
        pulse(1'b1, 1'b1);
        @(negedge CLK100MHZ);
        reset   = 1'b0;
        tick_in = 1'b1;
        @(negedge CLK100MHZ);
        push(3'd5, 5'd1, "reset_mid_phase");
        tick_in = 1'b0;
        @(negedge CLK100MHZ) tick_in = 1'b1;
        @(negedge CLK100MHZ) tick_in = 1'b0;
        reset = 1'b1;
        @(negedge CLK100MHZ);
        push(3'd5, 5'd1, "tick_ignored_in_reset");
        tick_exp(3'd0, 5'd10, "ped_cleared_by_reset");
        for (int k = 9; k >= 1; k--) tick_exp(3'd0, 5'(k), "post_reset_ns");
        tick_exp(3'd0, 5'd10, "ew_cleared_by_reset");

        for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge CLK100MHZ);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
